// File: rtl/av_power_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// av_power_sequencer : PLL / OV5640 / SDRAM / SCCB bring-up sequencer with retry
// Revision 1.0
// ----------------------------------------------------------------------------
module av_power_sequencer #(
  parameter int PLL_RST_CYC  = 1000,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int PWDN_CYC     = 250000,
  parameter int CAMRST_CYC   = 50000,
  parameter int SETTLE_CYC   = 1000000,
  parameter int CFG_TIMEOUT  = 2000000,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sdram_init_done,
  input  logic       sccb_cfg_done,
  output logic       pll_rst,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       sdram_init_start,
  output logic       sccb_cfg_start,
  output logic       sys_ready,
  output logic       seq_fail,
  output logic [3:0] seq_state,
  output logic [3:0] retry_cnt
);

  typedef enum logic [3:0] {
    ST_PLL_RST    = 4'd0,
    ST_LOCK_WAIT  = 4'd1,
    ST_CAM_PWDN   = 4'd2,
    ST_CAM_RST    = 4'd3,
    ST_CAM_SETTLE = 4'd4,
    ST_MEM_INIT   = 4'd5,
    ST_CAM_CFG    = 4'd6,
    ST_READY      = 4'd7,
    ST_FAIL       = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] C_PLL_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] C_LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_PWDN_LAST    = CNT_W'(PWDN_CYC - 1);
  localparam logic [CNT_W-1:0] C_CAMRST_LAST  = CNT_W'(CAMRST_CYC - 1);
  localparam logic [CNT_W-1:0] C_SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] C_CFG_LAST     = CNT_W'(CFG_TIMEOUT - 1);
  localparam logic [3:0]       C_MAX_RETRY    = 4'(MAX_RETRY);

  logic [1:0]       sync_q, sync_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             pll_rst_q, pll_rst_d;
  logic             cam_pwdn_q, cam_pwdn_d;
  logic             cam_rst_n_q, cam_rst_n_d;
  logic             sdram_init_start_q, sdram_init_start_d;
  logic             sccb_cfg_start_q, sccb_cfg_start_d;
  logic             sys_ready_q, sys_ready_d;
  logic             seq_fail_q, seq_fail_d;

  logic   locked_s;
  logic   lock_lost;
  logic   timeout;
  state_t retry_tgt;

  assign locked_s = sync_q[1];

  always_comb begin
    sync_d    = {sync_q[0], pll_locked};
    state_d   = state_q;
    retry_d   = retry_q;
    cnt_d     = cnt_q + 1'b1;
    timeout   = 1'b0;
    retry_tgt = ST_PLL_RST;
    lock_lost = !locked_s && (state_q >= ST_CAM_PWDN) && (state_q <= ST_READY);

    case (state_q)
      ST_PLL_RST:    if (cnt_q == C_PLL_RST_LAST) state_d = ST_LOCK_WAIT;
      ST_LOCK_WAIT: begin
        if (locked_s) begin
          state_d = ST_CAM_PWDN;
        end else if (cnt_q == C_LOCK_LAST) begin
          timeout   = 1'b1;
          retry_tgt = ST_PLL_RST;
        end
      end
      ST_CAM_PWDN:   if (cnt_q == C_PWDN_LAST)   state_d = ST_CAM_RST;
      ST_CAM_RST:    if (cnt_q == C_CAMRST_LAST) state_d = ST_CAM_SETTLE;
      ST_CAM_SETTLE: if (cnt_q == C_SETTLE_LAST) state_d = ST_MEM_INIT;
      ST_MEM_INIT:   if (sdram_init_done)        state_d = ST_CAM_CFG;
      ST_CAM_CFG: begin
        if (sccb_cfg_done) begin
          state_d = ST_READY;
        end else if (cnt_q == C_CFG_LAST) begin
          timeout   = 1'b1;
          retry_tgt = ST_CAM_PWDN;
        end
      end
      ST_READY, ST_FAIL: cnt_d = cnt_q;
      default:       state_d = ST_PLL_RST;
    endcase

    // Out of retries: a further timeout parks in FAIL without consuming one.
    if (timeout) begin
      if (retry_q == C_MAX_RETRY) begin
        state_d = ST_FAIL;
      end else begin
        state_d = retry_tgt;
        retry_d = retry_q + 4'd1;
      end
    end

    if (lock_lost) begin
      state_d = ST_PLL_RST;
      retry_d = retry_q;
    end

    if (state_d != state_q) cnt_d = '0;

    // Outputs are decoded from the next state so they move with the state register.
    pll_rst_d          = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
    cam_pwdn_d         = (state_d <= ST_CAM_PWDN) || (state_d == ST_FAIL);
    cam_rst_n_d        = (state_d >= ST_CAM_SETTLE) && (state_d <= ST_READY);
    sdram_init_start_d = (state_d == ST_MEM_INIT) && (state_q != ST_MEM_INIT);
    sccb_cfg_start_d   = (state_d == ST_CAM_CFG) && (state_q != ST_CAM_CFG);
    sys_ready_d        = (state_d == ST_READY);
    seq_fail_d         = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q             <= 2'b00;
      state_q            <= ST_PLL_RST;
      cnt_q              <= '0;
      retry_q            <= 4'd0;
      pll_rst_q          <= 1'b1;
      cam_pwdn_q         <= 1'b1;
      cam_rst_n_q        <= 1'b0;
      sdram_init_start_q <= 1'b0;
      sccb_cfg_start_q   <= 1'b0;
      sys_ready_q        <= 1'b0;
      seq_fail_q         <= 1'b0;
    end else begin
      sync_q             <= sync_d;
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      retry_q            <= retry_d;
      pll_rst_q          <= pll_rst_d;
      cam_pwdn_q         <= cam_pwdn_d;
      cam_rst_n_q        <= cam_rst_n_d;
      sdram_init_start_q <= sdram_init_start_d;
      sccb_cfg_start_q   <= sccb_cfg_start_d;
      sys_ready_q        <= sys_ready_d;
      seq_fail_q         <= seq_fail_d;
    end
  end

  assign pll_rst          = pll_rst_q;
  assign cam_pwdn         = cam_pwdn_q;
  assign cam_rst_n        = cam_rst_n_q;
  assign sdram_init_start = sdram_init_start_q;
  assign sccb_cfg_start   = sccb_cfg_start_q;
  assign sys_ready        = sys_ready_q;
  assign seq_fail         = seq_fail_q;
  assign seq_state        = state_q;
  assign retry_cnt        = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_av_power_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_av_power_sequencer : phase-level planner/scoreboard bench for the sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_av_power_sequencer;

  localparam int C_PLL    = 4;
  localparam int C_LT     = 8;
  localparam int C_PWDN   = 5;
  localparam int C_CAMRST = 3;
  localparam int C_SETTLE = 6;
  localparam int C_CFG    = 10;
  localparam int C_MAX    = 2;
  localparam int MAXE     = 16384;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       sdram_init_done;
  logic       sccb_cfg_done;
  logic       pll_rst;
  logic       cam_pwdn;
  logic       cam_rst_n;
  logic       sdram_init_start;
  logic       sccb_cfg_start;
  logic       sys_ready;
  logic       seq_fail;
  logic [3:0] seq_state;
  logic [3:0] retry_cnt;

  av_power_sequencer #(
    .PLL_RST_CYC (C_PLL),
    .LOCK_TIMEOUT(C_LT),
    .PWDN_CYC    (C_PWDN),
    .CAMRST_CYC  (C_CAMRST),
    .SETTLE_CYC  (C_SETTLE),
    .CFG_TIMEOUT (C_CFG),
    .MAX_RETRY   (C_MAX),
    .CNT_W       (24)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pll_locked      (pll_locked),
    .sdram_init_done (sdram_init_done),
    .sccb_cfg_done   (sccb_cfg_done),
    .pll_rst         (pll_rst),
    .cam_pwdn        (cam_pwdn),
    .cam_rst_n       (cam_rst_n),
    .sdram_init_start(sdram_init_start),
    .sccb_cfg_start  (sccb_cfg_start),
    .sys_ready       (sys_ready),
    .seq_fail        (seq_fail),
    .seq_state       (seq_state),
    .retry_cnt       (retry_cnt)
  );

  typedef struct {
    int code;
    int at;
    int retry;
  } exp_t;

  // Input schedules indexed by the absolute clock edge at which they are sampled.
  bit   rst_low [MAXE];
  bit   lock_s  [MAXE];
  bit   sd_s    [MAXE];
  bit   cd_s    [MAXE];
  exp_t exp_q[$];

  int cyc = 0;
  int pe;
  int cur_code;
  int end_edge;
  int vectors = 0;
  int miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  // Level outputs per state: {pll_rst, cam_pwdn, cam_rst_n, sys_ready, seq_fail}
  function automatic int exp_levels(input int code);
    case (code)
      0:       return 5'b11000;
      1, 2:    return 5'b01000;
      3:       return 5'b00000;
      4, 5, 6: return 5'b00100;
      7:       return 5'b00110;
      default: return 5'b11001;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, cyc - 1, act, expv);
    end
  endtask

  task automatic push_exp(input int code, input int at, input int retry);
    exp_t e;
    e.code  = code;
    e.at    = at;
    e.retry = retry;
    exp_q.push_back(e);
    cur_code = code;
  endtask

  task automatic mark_sd(input int from, input int to);
    for (int i = from; i <= to; i++) if (i >= 0 && i < MAXE) sd_s[i] = 1'b1;
  endtask

  task automatic mark_cd(input int from, input int to);
    for (int i = from; i <= to; i++) if (i >= 0 && i < MAXE) cd_s[i] = 1'b1;
  endtask

  // ev: 0 none, 1 lock drop in CAM_RST, 2 lock drop in CAM_SETTLE,
  //     3 lock drop in READY, 4 rst_n pulse in CAM_RST.
  task automatic plan_scenario(input int lock_fails, input int cfg_fails,
                               input int ev, input int force_c);
    int ph, ent, nx, nent, retry, lf, cf, lock_from, drop_at, j, k, c, p, guard;
    bit fired, done_sc;
    rst_low[pe]   = 1'b1;
    rst_low[pe+1] = 1'b1;
    if (cur_code != 0) push_exp(0, pe, 0);
    ph = 0; ent = pe + 1; retry = 0; lf = 0; cf = 0;
    lock_from = -1; drop_at = -1; fired = 1'b0; done_sc = 1'b0; guard = 0;
    while (!done_sc && guard < 64) begin
      guard++;
      nx = -1;
      nent = ent;
      case (ph)
        0: begin nx = 1; nent = ent + C_PLL; end
        1: begin
          if (lf < lock_fails) begin
            lf++;
            nent = ent + C_LT;
            if (retry == C_MAX) nx = 8; else begin retry++; nx = 0; end
          end else begin
            if (lock_from < 0) lock_from = ent + int'($urandom_range(C_LT, 1)) - 2;
            j = lock_from + 2 - ent;
            if (j < 1) j = 1;
            nx = 2;
            nent = ent + j;
          end
        end
        2: begin nx = 3; nent = ent + C_PWDN; end
        3: begin nx = 4; nent = ent + C_CAMRST; end
        4: begin
          nx = 5;
          nent = ent + C_SETTLE;
          if ($urandom_range(1, 0) == 1) begin
            p = ent + int'($urandom_range(C_SETTLE, 1));
            mark_sd(p, p);
            mark_cd(p, p);
          end
        end
        5: begin
          k = int'($urandom_range(4, 1));
          mark_sd(ent + k, ent + k + int'($urandom_range(2, 0)));
          nx = 6;
          nent = ent + k;
        end
        6: begin
          if (cf < cfg_fails) begin
            cf++;
            nent = ent + C_CFG;
            if (retry == C_MAX) nx = 8; else begin retry++; nx = 2; end
          end else begin
            c = (force_c > 0) ? force_c : int'($urandom_range(C_CFG, 1));
            mark_cd(ent + c, ent + c + int'($urandom_range(2, 0)));
            nx = 7;
            nent = ent + c;
          end
        end
        7:       nent = ent + int'($urandom_range(12, 6));
        default: nent = ent + int'($urandom_range(10, 4));
      endcase
      if (!fired && ((ev == 1 && ph == 3) || (ev == 2 && ph == 4) || (ev == 3 && ph == 7))) begin
        // A one-sample lock drop reaches the FSM two edges later.
        fired = 1'b1;
        nent = ent + int'($urandom_range(nent - ent, 1));
        drop_at = nent - 2;
        nx = 0;
      end else if (!fired && ev == 4 && ph == 3) begin
        fired = 1'b1;
        nent = ent + int'($urandom_range(C_CAMRST, 1));
        nx = -1;
      end
      if (nx >= 0) begin
        push_exp(nx, nent, retry);
        ph = nx;
        ent = nent;
      end else begin
        done_sc = 1'b1;
        pe = nent;
      end
    end
    if (lock_from >= 0) for (int i = lock_from; i < pe; i++) lock_s[i] = 1'b1;
    if (drop_at >= 0) lock_s[drop_at] = 1'b0;
  endtask

  // Input driver: values for the upcoming edge are applied on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc < MAXE) begin
        rst_n           = !rst_low[cyc];
        pll_locked      = lock_s[cyc];
        sdram_init_done = sd_s[cyc];
        sccb_cfg_done   = cd_s[cyc];
      end
    end
  end

  // Monitor: every state change pops one expected transition.
  initial begin
    int   prev_code;
    int   hold_code;
    int   hold_retry;
    exp_t e;
    prev_code  = 0;
    hold_code  = 0;
    hold_retry = 0;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        if (int'(seq_state) != prev_code) begin
          prev_code = int'(seq_state);
          if (exp_q.size() == 0) begin
            chk("unexpected_transition", int'(seq_state), hold_code);
          end else begin
            e = exp_q.pop_front();
            chk("state_code", int'(seq_state), e.code);
            chk("entry_edge", cyc - 1, e.at);
            chk("retry_at_entry", int'(retry_cnt), e.retry);
            chk("outputs_at_entry",
                int'({pll_rst, cam_pwdn, cam_rst_n, sys_ready, seq_fail,
                      sdram_init_start, sccb_cfg_start}),
                (exp_levels(e.code) << 2) | ((e.code == 5) ? 2 : 0) | ((e.code == 6) ? 1 : 0));
            hold_code  = e.code;
            hold_retry = e.retry;
          end
        end else begin
          chk("hold_outputs",
              int'({pll_rst, cam_pwdn, cam_rst_n, sys_ready, seq_fail,
                    sdram_init_start, sccb_cfg_start, retry_cnt}),
              (exp_levels(hold_code) << 6) | hold_retry);
        end
      end
    end
  end

  initial begin
    int lf, cfgf, ev;
    rst_n           = 1'b0;
    pll_locked      = 1'b0;
    sdram_init_done = 1'b0;
    sccb_cfg_done   = 1'b0;
    pe       = 0;
    cur_code = 0;
    plan_scenario(0, 0, 0, 0);
    plan_scenario(2, 0, 0, 0);
    plan_scenario(3, 0, 0, 0);
    plan_scenario(0, 1, 0, 2);
    plan_scenario(0, 0, 3, 0);
    plan_scenario(0, 0, 0, C_CFG);
    plan_scenario(0, 0, 4, 0);
    plan_scenario(1, 0, 1, 0);
    plan_scenario(0, 2, 2, 0);
    plan_scenario(0, 3, 0, 0);
    for (int n = 0; n < 24; n++) begin
      lf   = int'($urandom_range(3, 0));
      cfgf = (lf == 3) ? 0 : int'($urandom_range(3 - lf, 0));
      ev   = int'($urandom_range(4, 0));
      plan_scenario(lf, cfgf, ev, 0);
    end
    for (int i = pe; i < pe + 6; i++) rst_low[i] = 1'b1;
    if (cur_code != 0) push_exp(0, pe, 0);
    end_edge = pe + 6;

    wait (cyc >= end_edge + 2);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/av_power_sequencer.md
Name: av_power_sequencer

Overview:
- Sequences bring-up of the dual-camera/SDRAM video system: PLL reset, lock qualification, OV5640 power-down/reset timing, SDRAM init kick and SCCB register-config kick.
- Sits beside the clock/reset generator in the 50 MHz input clock domain.
- Drives the PLL areset and both camera control pins.
- Retries and recovers on PLL lock loss or camera config timeout, and reports system ready or a sticky failure.

Parameters:
- PLL_RST_CYC, 1000: cycles pll_rst is held high (20 us at 50 MHz).
- LOCK_TIMEOUT, 50000: max cycles waiting for synchronized lock before retry.
- PWDN_CYC, 250000: cycles cam_pwdn is held high after lock.
- CAMRST_CYC, 50000: cycles cam_rst_n is held low after PWDN release.
- SETTLE_CYC, 1000000: cycles after cam_rst_n release before SCCB access (20 ms).
- CFG_TIMEOUT, 2000000: max cycles waiting for sccb_cfg_done.
- MAX_RETRY, 3: retries allowed before FAIL (range 1..15).
- CNT_W, 24: width of the shared phase counter; must hold every *_CYC/TIMEOUT value.

Ports:
- clk, input, 1: 50 MHz system clock.
- rst_n, input, 1: reset.
- pll_locked, input, 1: PLL lock, asynchronous to clk.
- sdram_init_done, input, 1: level; SDRAM controller init complete.
- sccb_cfg_done, input, 1: level; camera register table written.
- pll_rst, output, 1: PLL areset, active high.
- cam_pwdn, output, 1: OV5640 PWDN, active high.
- cam_rst_n, output, 1: OV5640 RESETB, active low.
- sdram_init_start, output, 1: 1-cycle pulse.
- sccb_cfg_start, output, 1: 1-cycle pulse.
- sys_ready, output, 1: bring-up complete.
- seq_fail, output, 1: sticky failure.
- seq_state, output, 4: current state code.
- retry_cnt, output, 4: retries consumed.

Behaviour:
- Single clock clk. Reset is synchronous, active-low on rst_n.
- Reset values: state PLL_RST, counter 0, retry_cnt 0, pll_rst 1, cam_pwdn 1, cam_rst_n 0, both start pulses 0, sys_ready 0, seq_fail 0.
- pll_locked passes through a 2-FF synchronizer; locked_s lags pll_locked by 2 cycles. Synchronizer flops clear to 0 on reset.
- Moore FSM with registered outputs. Outputs change in the same cycle the state register changes.
- The counter clears to 0 on every state entry. Timed states exit when cnt == N-1, so each lasts exactly N cycles.
- State codes and outputs, listed as code STATE: pll_rst / cam_pwdn / cam_rst_n:
  - 0 PLL_RST: 1/1/0. Exit after PLL_RST_CYC cycles to LOCK_WAIT.
  - 1 LOCK_WAIT: 0/1/0.
    - locked_s == 1: go to CAM_PWDN.
    - Otherwise, when cnt == LOCK_TIMEOUT-1: retry to PLL_RST.
  - 2 CAM_PWDN: 0/1/0. Exit after PWDN_CYC cycles to CAM_RST.
  - 3 CAM_RST: 0/0/0. Exit after CAMRST_CYC cycles to CAM_SETTLE.
  - 4 CAM_SETTLE: 0/0/1. Exit after SETTLE_CYC cycles to MEM_INIT.
  - 5 MEM_INIT: 0/0/1. sdram_init_start = 1 on the first cycle only. Exit when sdram_init_done == 1 to CAM_CFG. No timeout.
  - 6 CAM_CFG: 0/0/1. sccb_cfg_start = 1 on the first cycle only.
    - sccb_cfg_done == 1: go to READY.
    - Otherwise, when cnt == CFG_TIMEOUT-1: retry to CAM_PWDN (camera power-cycle only; PLL untouched).
  - 7 READY: 0/0/1, sys_ready 1. Held indefinitely.
  - 8 FAIL: 1/1/0, seq_fail 1. Absorbing until rst_n.
- Retry: retry_cnt increments on each timeout exit.
  - If retry_cnt == MAX_RETRY at the moment of a timeout, go to FAIL instead; retry_cnt does not increment.
  - retry_cnt never wraps or saturates above MAX_RETRY.
- Lock loss: locked_s == 0 in any of states 2..7 sends the FSM to PLL_RST on the next clock.
  - sys_ready drops with that transition.
  - retry_cnt is not incremented.
- Priority within a cycle: lock loss > done input > timeout.
  - A done input sampled on the timeout cycle counts as success.
- sdram_init_done or sccb_cfg_done asserted outside their wait states is ignored.
- A start pulse re-issues on every entry to its state, including entries after a retry or a lock-loss recovery.
- Reset asserted mid-sequence returns every output to its reset value on the next clock, regardless of state.

Test Plan:
- All tests use overrides PLL_RST_CYC=4, LOCK_TIMEOUT=8, PWDN_CYC=5, CAMRST_CYC=3, SETTLE_CYC=6, CFG_TIMEOUT=10, MAX_RETRY=2.
- Nominal bring-up:
  - Stimulus: pll_locked high from reset release; dones 3 cycles after each start.
  - Required: pll_rst high exactly 4 cycles; cam_pwdn falls 5 cycles after LOCK_WAIT exit; cam_rst_n rises 3 cycles later; sdram_init_start pulses 6 cycles after that.
  - Required end state: sys_ready=1, seq_state=7, retry_cnt=0.
- Lock timeout then recovery:
  - Stimulus: pll_locked low through two LOCK_WAIT windows, then high.
  - Required: two PLL_RST re-entries, retry_cnt=2, then normal completion to READY.
- Lock never arrives:
  - Stimulus: pll_locked held low.
  - Required: after the 3rd LOCK_WAIT timeout, seq_state=8, seq_fail=1, pll_rst=1, cam_pwdn=1; state stays there until rst_n pulses low.
- Config timeout:
  - Stimulus: sccb_cfg_done held low for the first CAM_CFG, high 2 cycles into the second.
  - Required: return to CAM_PWDN with cam_pwdn=1 and pll_rst=0; retry_cnt=1; second sccb_cfg_start pulse issued; READY reached.
- Lock loss in READY:
  - Stimulus: drop pll_locked for 1 cycle.
  - Required: sys_ready falls 3 cycles after the drop (2 synchronizer + 1 state), pll_rst=1, retry_cnt unchanged, full re-sequence completes.
- Simultaneous events:
  - Stimulus: sccb_cfg_done rises on cnt==9 of CAM_CFG.
  - Required: READY, retry_cnt unchanged.
  - Stimulus: rst_n low during CAM_RST.
  - Required: reset values on the next clock.
